// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered channel reset sequencer with per-channel clock-enable dividers.
// Optional watchdog enabled by defining RST_SEQ_WDOG_EN; when undefined, wdog_kick is
// ignored and wdog_fire is tied low.
// A watchdog build needs WDOG_CYCLES >= 2.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HOLD    | all channels in reset, cnt counts up to HOLD_CYCLES-1
// S_STAGGER | channels released one by one, STAGGER cycles apart
// S_RUN     | all channels released, waits for sw reset or watchdog expiry
module rst_seq_gen #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int DIV_W       = 4,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    wdog_kick,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic                    all_rdy,
  output logic                    wdog_fire
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 restart;
  logic [DIV_W-1:0]     div_cnt [NUM_CH];
  logic [DIV_W-1:0]     cfg_lat [NUM_CH];

`ifdef RST_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wdog_cnt;

  // A fire pulse is itself the restart request, so expiry resequences on the next edge.
  assign restart = sw_rst_req | wdog_fire;

  // Watchdog: counts RUN cycles since the last kick; fire is registered so it shows
  // in the same cycle the count reaches WDOG_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_fire <= 1'b0;
    end else if (restart || state != S_RUN || wdog_kick) begin
      wdog_cnt  <= '0;
      wdog_fire <= 1'b0;
    end else begin
      wdog_cnt  <= wdog_cnt + 1'b1;
      wdog_fire <= (wdog_cnt == WD_W'(WDOG_CYCLES - 2));
    end
  end
`else
  logic wdog_kick_unused;

  assign restart          = sw_rst_req;
  assign wdog_fire        = 1'b0;
  assign wdog_kick_unused = wdog_kick;
`endif

  // Sequencer FSM: hold, staggered release, run; restart returns to a full hold.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state   <= S_HOLD;
      cnt     <= '0;
      idx     <= '0;
      ch_rst  <= '1;
      all_rdy <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            ch_rst[0] <= 1'b0;
            cnt       <= '0;
            if (NUM_CH == 1) begin
              state   <= S_RUN;
              all_rdy <= 1'b1;
            end else begin
              state <= S_STAGGER;
              idx   <= IDX_W'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STAGGER: begin
          if (cnt == CNT_W'(STAGGER - 1)) begin
            ch_rst[idx] <= 1'b0;
            cnt         <= '0;
            if (idx == IDX_W'(NUM_CH - 1)) begin
              state   <= S_RUN;
              all_rdy <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

  // Per-channel dividers; cfg is captured only while the counter sits at zero so
  // a new divide ratio applies from the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt[i] <= '0;
        cfg_lat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_rst[i] || restart) begin
          div_cnt[i] <= '0;
        end else if (div_cnt[i] == cfg_lat[i]) begin
          div_cnt[i] <= '0;
        end else begin
          div_cnt[i] <= div_cnt[i] + 1'b1;
        end
        if (div_cnt[i] == '0) begin
          cfg_lat[i] <= div_cfg[i*DIV_W +: DIV_W];
        end
      end
    end
  end

  // Clock-enable decode from registered state only.
  always_comb begin
    ch_ce = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ce[i] = !ch_rst[i] && (div_cnt[i] == cfg_lat[i]);
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed checks of the reset sequence, dividers, sw restarts and
// (when RST_SEQ_WDOG_EN is defined) the watchdog, using a cycle-stamped expectation queue.
module tb_rst_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_rst_req = 1'b0;
  logic        wdog_kick = 1'b0;
  logic [15:0] div_cfg = 16'h5230;
  logic [3:0]  ch_rst;
  logic [3:0]  ch_ce;
  logic        all_rdy;
  logic        wdog_fire;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   ticks = 0;
  int   base = 0;
  bit   counting = 1'b0;
  int   total = 0;
  int   bad = 0;

  rst_seq_gen #(
    .NUM_CH(4), .HOLD_CYCLES(16), .STAGGER(4), .DIV_W(4), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .div_cfg(div_cfg),
    .wdog_kick(wdog_kick), .ch_rst(ch_rst), .ch_ce(ch_ce),
    .all_rdy(all_rdy), .wdog_fire(wdog_fire)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ticks <= ticks + 1;

  function automatic void push(int c, int s, logic [31:0] e, string n);
    chk_t t;
    t.cyc = c; t.sel = s; t.exp = e; t.name = n;
    q.push_back(t);
  endfunction

  function automatic logic [31:0] pick(int s);
    case (s)
      0: pick = 32'(ch_rst);
      1: pick = 32'(ch_ce);
      2: pick = 32'(ch_ce[1]);
      3: pick = 32'(all_rdy);
      4: pick = 32'(wdog_fire);
      5: pick = 32'(ch_ce[3]);
      default: pick = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic wait_cyc(int k);
    while ((ticks - base) < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sw(int k);
    wait_cyc(k);
    sw_rst_req = 1'b1;
    wait_cyc(k + 1);
    sw_rst_req = 1'b0;
  endtask

  // Monitor: every cycle, compare all expectations stamped for this cycle.
  initial begin
    logic [31:0] act;
    int c;
    wait (counting);
    forever begin
      @(negedge clk);
      c = ticks - base;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= c) begin
          act = pick(q[i].sel);
          total++;
          if (q[i].cyc < c || act !== q[i].exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h (checked at %0d)",
                     q[i].name, q[i].cyc, act, q[i].exp, c);
          end
          q.delete(i);
        end
      end
    end
  end

  // Stimulus: push expectations for each phase, then drive it.
  initial begin
    push(0, 0, 32'hF, "rst_state_ch_rst");
    push(0, 1, 32'h0, "rst_state_ch_ce");
    push(0, 3, 32'h0, "rst_state_all_rdy");
    push(15, 0, 32'hF, "hold_end");
    push(16, 0, 32'hE, "ch0_release");
    push(16, 1, 32'h1, "ch0_ce_first");
    push(19, 1, 32'h1, "ce_ch1_in_reset");
    push(20, 0, 32'hC, "ch1_release");
    push(22, 2, 32'h0, "ch1_ce_gap");
    push(23, 2, 32'h1, "ch1_ce_first");
    push(24, 0, 32'h8, "ch2_release");
    push(26, 1, 32'h5, "ce_vec_26");
    push(27, 0, 32'h8, "ch3_still_rst");
    push(27, 3, 32'h0, "rdy_before_last");
    push(27, 2, 32'h1, "ch1_ce_kept_27");
    push(28, 0, 32'h0, "ch3_release");
    push(28, 3, 32'h1, "all_rdy_set");
    push(28, 2, 32'h0, "ch1_ce_28");
    push(29, 1, 32'h7, "ce_vec_29");
    push(30, 2, 32'h0, "ch1_ce_30");
    push(31, 2, 32'h1, "ch1_ce_31");
    push(32, 5, 32'h0, "ch3_ce_32");
    push(33, 5, 32'h1, "ch3_ce_first");
    push(33, 1, 32'hB, "ce_vec_33");

    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    base = ticks;
    counting = 1'b1;

    wait_cyc(25);
    div_cfg = 16'h5210;

    push(41, 0, 32'hF, "sw_run_ch_rst");
    push(41, 3, 32'h0, "sw_run_all_rdy");
    push(41, 1, 32'h0, "sw_run_ch_ce");
    push(56, 0, 32'hF, "sw_run_hold_end");
    push(57, 0, 32'hE, "sw_run_ch0_rel");
    push(57, 1, 32'h1, "sw_run_ch0_ce");
    push(68, 3, 32'h0, "sw_run_rdy_68");
    push(69, 3, 32'h1, "sw_run_rdy_69");
    push(69, 0, 32'h0, "sw_run_all_rel");
    pulse_sw(40);

    push(81, 0, 32'hF, "sw2_ch_rst");
    push(97, 0, 32'hE, "sw2_ch0_rel");
    push(103, 0, 32'hC, "sw2_mid_stagger");
    pulse_sw(80);

    push(104, 0, 32'hF, "stagger_req_rearm");
    push(104, 3, 32'h0, "stagger_req_rdy");
    pulse_sw(103);

    push(120, 0, 32'hF, "hold_req_no_rel");
    push(126, 0, 32'hF, "hold_req_126");
    push(127, 0, 32'hE, "hold_req_ch0_rel");
    push(138, 3, 32'h0, "hold_req_rdy_138");
    push(139, 3, 32'h1, "hold_req_rdy_139");
    pulse_sw(110);

`ifdef RST_SEQ_WDOG_EN
    push(175, 4, 32'h0, "wdog_kicked");
    push(175, 3, 32'h1, "wdog_kicked_rdy");
    push(179, 4, 32'h0, "wdog_pre_fire");
    push(180, 4, 32'h1, "wdog_fire");
    push(181, 4, 32'h0, "wdog_fire_pulse");
    push(181, 0, 32'hF, "wdog_reseq_rst");
    push(181, 3, 32'h0, "wdog_reseq_rdy");
    push(197, 0, 32'hE, "wdog_reseq_ch0");
`else
    push(175, 4, 32'h0, "wdog_off_175");
    push(175, 3, 32'h1, "wdog_off_rdy_175");
    push(180, 4, 32'h0, "wdog_off_180");
    push(181, 3, 32'h1, "wdog_off_rdy_181");
    push(181, 0, 32'h0, "wdog_off_ch_rst");
`endif
    for (int k = 140; k <= 172; k += 4) begin
      wait_cyc(k);
      wdog_kick = 1'b1;
      wait_cyc(k + 1);
      wdog_kick = 1'b0;
    end

    wait_cyc(200);
    for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d checks left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
